// File: rtl/sdr_app_pkg.sv
// -----------------------------------------------------------------------------
// sdr_app_pkg
// Shared definitions for the SDRAM application-side traffic master.
//   - default application widths (overridable at compile time through the
//     APP_AW / APP_DW / APP_RW macros)
//   - FSM state enumeration used by sdr_app_master
//   - error-counter width and a saturating increment helper used by
//     sdr_app_pattern
// Compile this file before the other rtl/ files so the width macros exist.
// -----------------------------------------------------------------------------
`ifndef APP_AW
`define APP_AW 32
`endif
`ifndef APP_DW
`define APP_DW 32
`endif
`ifndef APP_RW
`define APP_RW 8
`endif

package sdr_app_pkg;

    // Burst-master state machine states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Width and ceiling of the read-mismatch counter
    localparam int              ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    // Increment that sticks at the all-ones ceiling instead of wrapping
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        return (value == ERR_MAX) ? value : value + ERR_W'(1);
    endfunction

endpackage

// File: rtl/sdr_app_pattern.sv
// -----------------------------------------------------------------------------
// sdr_app_pattern
// Data pattern generator and read checker for sdr_app_master.
// The pattern for beat i of a burst is seed + i (modulo 2^DW). The same
// value is driven as write data and used as the expected read data.
//
// Optional feature macro: SDR_APP_MASTER_CHECK_EN
//   defined   : every checked read beat is compared against the pattern and
//               mismatches are counted in a saturating 16-bit counter
//   undefined : no comparator is built and err_cnt is tied to zero
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (clears err_cnt)
//   seed     in   DW  registered burst seed
//   beat     in   RW  current beat index within the burst
//   rd_data  in   DW  read beat from the controller
//   check    in   1   compare rd_data against the pattern this cycle
//   wr_data  out  DW  pattern value for the current beat
//   err_cnt  out  16  saturating mismatch count, held across bursts
// -----------------------------------------------------------------------------
module sdr_app_pattern
    import sdr_app_pkg::*;
#(
    parameter int DW = `APP_DW,
    parameter int RW = `APP_RW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DW-1:0]    seed,
    input  logic [RW-1:0]    beat,
    input  logic [DW-1:0]    rd_data,
    input  logic             check,
    output logic [DW-1:0]    wr_data,
    output logic [ERR_W-1:0] err_cnt
);

    // Pattern value: the beat index is zero-extended and added to the seed,
    // wrapping naturally at the data width.
    assign wr_data = seed + DW'(beat);

`ifdef SDR_APP_MASTER_CHECK_EN

    logic mismatch;

    assign mismatch = check && (rd_data != wr_data);

    // Mismatch counter survives from burst to burst; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

`else

    // Read beats are only counted by the master in this build, so the
    // comparator inputs have no load here.
    logic unused_check_inputs;

    assign unused_check_inputs = ^{clk, reset, rd_data, check};
    assign err_cnt             = '0;

`endif

endmodule

// File: rtl/sdr_app_master.sv
// -----------------------------------------------------------------------------
// sdr_app_master
// Application-side traffic master for an SDRAM controller. Accepts one user
// command at a time, issues a single request to the controller, then either
// streams a seed+index write pattern or checks returned read data against
// the same pattern.
//
// Optional feature macro: SDR_APP_MASTER_CHECK_EN (read data comparison and
// err_cnt; without it err_cnt stays 0 and read beats are only counted).
//
// Ports
//   sdram_clk        in   single clock, rising edge
//   reset            in   synchronous active-high reset
//   cmd_valid        in   user command offered
//   cmd_ready        out  idle; command taken when cmd_valid && cmd_ready
//   cmd_wr_n         in   0 = write, 1 = read
//   cmd_addr         in   AW start address
//   cmd_len          in   RW burst length in beats (0 = no transfer)
//   cmd_seed         in   DW data pattern seed
//   app_req          out  request to controller, held until app_req_ack
//   app_req_addr     out  AW registered address
//   app_req_len      out  RW registered length
//   app_req_wr_n     out  registered direction
//   app_req_wrap     out  always 0
//   app_wr_data      out  DW current write beat (seed + beat index)
//   app_wr_en_n      out  DW/8 byte enables, always all enabled (0)
//   app_req_ack      in   controller accepted the request
//   app_wr_next_req  in   controller consumes the current write beat
//   app_rd_data      in   DW read beat
//   app_rd_valid     in   app_rd_data valid
//   app_last_rd      in   final read beat marker
//   app_last_wr      in   final write beat marker
//   done             out  one-cycle pulse at burst completion
//   err_cnt          out  16 saturating read-mismatch count
//   proto_err        out  sticky controller protocol violation
// -----------------------------------------------------------------------------
module sdr_app_master
    import sdr_app_pkg::*;
#(
    parameter int AW = `APP_AW,
    parameter int DW = `APP_DW,
    parameter int RW = `APP_RW
) (
    input  logic             sdram_clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr_n,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [RW-1:0]    cmd_len,
    input  logic [DW-1:0]    cmd_seed,
    output logic             app_req,
    output logic [AW-1:0]    app_req_addr,
    output logic [RW-1:0]    app_req_len,
    output logic             app_req_wr_n,
    output logic             app_req_wrap,
    output logic [DW-1:0]    app_wr_data,
    output logic [DW/8-1:0]  app_wr_en_n,
    input  logic             app_req_ack,
    input  logic             app_wr_next_req,
    input  logic [DW-1:0]    app_rd_data,
    input  logic             app_rd_valid,
    input  logic             app_last_rd,
    input  logic             app_last_wr,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             proto_err
);

    state_t          state;
    logic [DW-1:0]   seed_q;
    logic [RW-1:0]   beat;

    logic            last_beat;
    logic            wr_take;
    logic            rd_take;
    logic            rd_extra;
    logic            early_wr;
    logic            stray_beat;
    logic [RW-1:0]   rd_count_next;

    assign app_req_wrap = 1'b0;
    assign app_wr_en_n  = '0;

    // Beat bookkeeping. A write beat may be consumed in the same cycle the
    // request is acknowledged, so the REQ state counts as a data state when
    // app_req_ack is high. Read beats past the programmed length are not
    // counted; they only flag a protocol error.
    assign last_beat     = (beat == app_req_len - RW'(1));
    assign wr_take       = !app_req_wr_n && app_wr_next_req &&
                           ((state == ST_WDATA) || ((state == ST_REQ) && app_req_ack));
    assign rd_take       = (state == ST_RDATA) && app_rd_valid && (beat != app_req_len);
    assign rd_extra      = (state == ST_RDATA) && app_rd_valid && (beat == app_req_len);
    assign rd_count_next = beat + RW'(rd_take);

    // Write data consumed before the controller has acknowledged the request
    // is not attributed to any beat.
    assign early_wr   = (state == ST_REQ) && !app_req_wr_n && app_wr_next_req && !app_req_ack;
    assign stray_beat = ((state == ST_IDLE) || (state == ST_DONE)) &&
                        (app_rd_valid || app_wr_next_req);

    // Main control FSM. All handshake outputs are flops so the controller
    // sees glitch-free request/address/done signals. The write-beat handling
    // sits after the case statement because it applies both in WDATA and in
    // the acknowledging REQ cycle, and its exit to DONE must win over the
    // REQ->WDATA transition.
    always_ff @(posedge sdram_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b1;
            app_req      <= 1'b0;
            done         <= 1'b0;
            proto_err    <= 1'b0;
            app_req_addr <= '0;
            app_req_len  <= '0;
            app_req_wr_n <= 1'b0;
            seed_q       <= '0;
            beat         <= '0;
        end else begin
            done <= 1'b0;

            if (stray_beat || rd_extra || early_wr) begin
                proto_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (cmd_len != '0) begin
                            app_req_addr <= cmd_addr;
                            app_req_len  <= cmd_len;
                            app_req_wr_n <= cmd_wr_n;
                            seed_q       <= cmd_seed;
                            beat         <= '0;
                            app_req      <= 1'b1;
                            state        <= ST_REQ;
                        end else begin
                            // Empty command: complete without touching the controller
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end

                ST_REQ: begin
                    if (app_req_ack) begin
                        app_req <= 1'b0;
                        state   <= app_req_wr_n ? ST_RDATA : ST_WDATA;
                    end
                end

                ST_WDATA: begin
                end

                ST_RDATA: begin
                    if (rd_take) begin
                        beat <= beat + RW'(1);
                    end
                    // The controller decides when the read ends; a short or
                    // long burst is still closed but flagged.
                    if (app_last_rd) begin
                        if (rd_count_next != app_req_len) begin
                            proto_err <= 1'b1;
                        end
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    cmd_ready <= 1'b1;
                    app_req   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase

            if (wr_take) begin
                beat <= beat + RW'(1);
                if (last_beat || app_last_wr) begin
                    // A last marker on an earlier beat aborts the burst
                    if (!last_beat) begin
                        proto_err <= 1'b1;
                    end
                    app_req <= 1'b0;
                    done    <= 1'b1;
                    state   <= ST_DONE;
                end
            end
        end
    end

    sdr_app_pattern #(
        .DW (DW),
        .RW (RW)
    ) u_pattern (
        .clk     (sdram_clk),
        .reset   (reset),
        .seed    (seed_q),
        .beat    (beat),
        .rd_data (app_rd_data),
        .check   (rd_take),
        .wr_data (app_wr_data),
        .err_cnt (err_cnt)
    );

endmodule

// File: tb/tb_sdr_app_master.sv
// -----------------------------------------------------------------------------
// tb_sdr_app_master
// Self-checking bench for sdr_app_master. A controller stand-in answers
// requests with randomized ack delays and beat gaps; expected write data,
// read mismatch counts and handshake timing come from the burst rules
// (data = seed + beat index, one done pulse after the last beat).
// -----------------------------------------------------------------------------
module tb_sdr_app_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 8;

    logic            sdram_clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_wr_n;
    logic [AW-1:0]   cmd_addr;
    logic [RW-1:0]   cmd_len;
    logic [DW-1:0]   cmd_seed;
    logic            app_req;
    logic [AW-1:0]   app_req_addr;
    logic [RW-1:0]   app_req_len;
    logic            app_req_wr_n;
    logic            app_req_wrap;
    logic [DW-1:0]   app_wr_data;
    logic [DW/8-1:0] app_wr_en_n;
    logic            app_req_ack;
    logic            app_wr_next_req;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_valid;
    logic            app_last_rd;
    logic            app_last_wr;
    logic            done;
    logic [15:0]     err_cnt;
    logic            proto_err;

    int total   = 0;
    int bad     = 0;
    int exp_err = 0;

    always #5 sdram_clk = ~sdram_clk;

    sdr_app_master #(
        .AW (AW),
        .DW (DW),
        .RW (RW)
    ) dut (
        .sdram_clk       (sdram_clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_wr_n        (cmd_wr_n),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .cmd_seed        (cmd_seed),
        .app_req         (app_req),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_wrap    (app_req_wrap),
        .app_wr_data     (app_wr_data),
        .app_wr_en_n     (app_wr_en_n),
        .app_req_ack     (app_req_ack),
        .app_wr_next_req (app_wr_next_req),
        .app_rd_data     (app_rd_data),
        .app_rd_valid    (app_rd_valid),
        .app_last_rd     (app_last_rd),
        .app_last_wr     (app_last_wr),
        .done            (done),
        .err_cnt         (err_cnt),
        .proto_err       (proto_err)
    );

    // Expected mismatch count, saturating at 16 bits
    function automatic logic [15:0] exp_err_cnt();
        return (exp_err > 65535) ? 16'hFFFF : 16'(exp_err);
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_valid       = 1'b0;
        cmd_wr_n        = 1'b0;
        cmd_addr        = '0;
        cmd_len         = '0;
        cmd_seed        = '0;
        app_req_ack     = 1'b0;
        app_wr_next_req = 1'b0;
        app_rd_data     = '0;
        app_rd_valid    = 1'b0;
        app_last_rd     = 1'b0;
        app_last_wr     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_err = 0;
    endtask

    // Present one command for one cycle (block must be idle)
    task automatic issue_cmd(input logic wr_n, input logic [AW-1:0] addr,
                             input logic [RW-1:0] len, input logic [DW-1:0] seed);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL cmd_ready_before_cmd actual=%b required=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_wr_n  = wr_n;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_seed  = seed;
        tick();
        clear_inputs();
    endtask

    // Check the done pulse and return to idle after a burst
    task automatic check_finish(input string name, input logic exp_proto);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s done_pulse actual=%b required=1", name, done);
        end
        total++;
        if (app_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s req_at_done actual=%b required=0", name, app_req);
        end
        total++;
        if (err_cnt !== exp_err_cnt()) begin
            bad++;
            $display("[TB] FAIL %s err_cnt actual=%0d required=%0d", name, err_cnt, exp_err_cnt());
        end
        total++;
        if (proto_err !== exp_proto) begin
            bad++;
            $display("[TB] FAIL %s proto_err actual=%b required=%b", name, proto_err, exp_proto);
        end
        tick();
        total++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s back_to_idle done=%b cmd_ready=%b required done=0 cmd_ready=1",
                     name, done, cmd_ready);
        end
    endtask

    // Write burst with the controller acknowledging after ack_delay cycles and
    // consuming beats with a gap_pct percent chance of idling each cycle
    task automatic run_write(input string name, input logic [AW-1:0] addr,
                             input logic [RW-1:0] len, input logic [DW-1:0] seed,
                             input int ack_delay, input int gap_pct);
        int n;
        int beats;
        int cyc;
        bit acked;
        logic [DW-1:0] exp_data;
        n     = int'(len);
        beats = 0;
        cyc   = 0;
        acked = 1'b0;
        issue_cmd(1'b0, addr, len, seed);
        while (beats < n && cyc < 500) begin
            exp_data = seed + DW'(beats);
            total++;
            if (app_req !== (acked ? 1'b0 : 1'b1)) begin
                bad++;
                $display("[TB] FAIL %s app_req cyc=%0d actual=%b required=%b", name, cyc, app_req, !acked);
            end
            if (!acked) begin
                total++;
                if (app_req_addr !== addr || app_req_len !== len || app_req_wr_n !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL %s req_fields actual=%h/%0d/%b required=%h/%0d/0",
                             name, app_req_addr, app_req_len, app_req_wr_n, addr, len);
                end
            end
            total++;
            if (app_wr_data !== exp_data || done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s wr_data beat=%0d actual=%h done=%b required=%h done=0",
                         name, beats, app_wr_data, done, exp_data);
            end
            app_req_ack     = !acked && (cyc >= ack_delay);
            app_wr_next_req = (acked || app_req_ack) && ($urandom_range(0, 99) >= gap_pct);
            app_last_wr     = app_wr_next_req && (beats == n - 1);
            tick();
            if (app_req_ack)     acked = 1'b1;
            if (app_wr_next_req) beats++;
            clear_inputs();
            cyc++;
        end
        if (beats < n) begin
            total++;
            bad++;
            $display("[TB] FAIL %s write_timeout beats=%0d required=%0d", name, beats, n);
        end
        check_finish(name, 1'b0);
    endtask

    // Read burst; corrupt_pct percent of beats plus beat force_beat are
    // returned with one flipped bit
    task automatic run_read(input string name, input logic [AW-1:0] addr,
                            input logic [RW-1:0] len, input logic [DW-1:0] seed,
                            input int ack_delay, input int gap_pct,
                            input int corrupt_pct, input int force_beat);
        int n;
        int beats;
        int cyc;
        int nbad;
        bit acked;
        bit corrupt;
        logic [DW-1:0] flip;
        n     = int'(len);
        beats = 0;
        cyc   = 0;
        nbad  = 0;
        acked = 1'b0;
        issue_cmd(1'b1, addr, len, seed);
        while (beats < n && cyc < 500) begin
            total++;
            if (app_req !== (acked ? 1'b0 : 1'b1) || done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s app_req cyc=%0d actual=%b done=%b required=%b done=0",
                         name, cyc, app_req, done, !acked);
            end
            if (!acked) begin
                total++;
                if (app_req_addr !== addr || app_req_len !== len || app_req_wr_n !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL %s req_fields actual=%h/%0d/%b required=%h/%0d/1",
                             name, app_req_addr, app_req_len, app_req_wr_n, addr, len);
                end
            end
            app_req_ack = !acked && (cyc >= ack_delay);
            if (acked && ($urandom_range(0, 99) >= gap_pct)) begin
                corrupt = (beats == force_beat) || ($urandom_range(0, 99) < corrupt_pct);
                flip    = '0;
                if (corrupt) begin
                    flip[$urandom_range(0, DW - 1)] = 1'b1;
                    nbad++;
                end
                app_rd_valid = 1'b1;
                app_rd_data  = (seed + DW'(beats)) ^ flip;
                app_last_rd  = (beats == n - 1);
            end else begin
                app_rd_data = $urandom;
            end
            tick();
            if (app_req_ack)  acked = 1'b1;
            if (app_rd_valid) beats++;
            clear_inputs();
            cyc++;
        end
        if (beats < n) begin
            total++;
            bad++;
            $display("[TB] FAIL %s read_timeout beats=%0d required=%0d", name, beats, n);
        end
`ifdef SDR_APP_MASTER_CHECK_EN
        exp_err += nbad;
`endif
        check_finish(name, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (cmd_ready !== 1'b1 || app_req !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_handshake cmd_ready=%b app_req=%b done=%b required 1/0/0",
                     cmd_ready, app_req, done);
        end
        total++;
        if (err_cnt !== 16'h0 || proto_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_errors err_cnt=%0d proto_err=%b required 0/0", err_cnt, proto_err);
        end
        total++;
        if (app_req_addr !== '0 || app_req_len !== '0 || app_req_wr_n !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_fields actual=%h/%0d/%b required 0/0/0",
                     app_req_addr, app_req_len, app_req_wr_n);
        end
        total++;
        if (app_wr_en_n !== '0 || app_req_wrap !== 1'b0 || app_wr_data !== '0) begin
            bad++;
            $display("[TB] FAIL reset_constants en_n=%h wrap=%b data=%h required 0/0/0",
                     app_wr_en_n, app_req_wrap, app_wr_data);
        end
    endtask

    task automatic test_write_basic();
        run_write("write_basic", 32'h100, 8'd4, 32'hA000_0000, 0, 0);
    endtask

    task automatic test_read_corrupt();
        run_read("read_corrupt", 32'h200, 8'd8, 32'd5, 1, 0, 0, 3);
    endtask

    task automatic test_ack_delay();
        run_write("ack_delay_wr", 32'h0BAD_F00C, 8'd3, 32'h1234_5678, 10, 20);
        run_read("ack_delay_rd", 32'h0000_0FF0, 8'd2, 32'h8765_4321, 10, 20, 0, -1);
    endtask

    task automatic test_zero_len();
        issue_cmd(1'b0, 32'h300, 8'd0, 32'h55);
        total++;
        if (app_req !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_len_done app_req=%b done=%b cmd_ready=%b required 0/1/0",
                     app_req, done, cmd_ready);
        end
        tick();
        total++;
        if (app_req !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL zero_len_idle app_req=%b done=%b cmd_ready=%b required 0/0/1",
                     app_req, done, cmd_ready);
        end
    endtask

    task automatic test_write_wrap();
        run_write("write_wrap", 32'h400, 8'd2, 32'hFFFF_FFFF, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                run_write("rand_wr", $urandom, RW'($urandom_range(1, 20)), $urandom,
                          $urandom_range(0, 5), 30);
            end else begin
                run_read("rand_rd", $urandom, RW'($urandom_range(1, 20)), $urandom,
                         $urandom_range(0, 5), 30, 20, -1);
            end
        end
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL random_proto_err actual=%b required=0", proto_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        // Reset while a request is pending drops app_req at that edge
        issue_cmd(1'b0, 32'h500, 8'd4, 32'h10);
        total++;
        if (app_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_req_pending actual=%b required=1", app_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (app_req !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_req_reset app_req=%b cmd_ready=%b required 0/1", app_req, cmd_ready);
        end
        // Reset in WDATA after beats 0 and 1 were consumed
        issue_cmd(1'b0, 32'h600, 8'd4, 32'h20);
        app_req_ack     = 1'b1;
        app_wr_next_req = 1'b1;
        tick();
        clear_inputs();
        app_wr_next_req = 1'b1;
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_err = 0;
        total++;
        if (app_req !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 ||
            err_cnt !== 16'h0 || app_req_addr !== '0) begin
            bad++;
            $display("[TB] FAIL mid_wdata_reset app_req=%b cmd_ready=%b done=%b err_cnt=%0d addr=%h required 0/1/0/0/0",
                     app_req, cmd_ready, done, err_cnt, app_req_addr);
        end
    endtask

    task automatic test_stray_idle();
        do_reset();
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stray_before actual=%b required=0", proto_err);
        end
        app_rd_valid = 1'b1;
        app_rd_data  = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        total++;
        if (proto_err !== 1'b1 || cmd_ready !== 1'b1 || err_cnt !== 16'h0) begin
            bad++;
            $display("[TB] FAIL stray_idle proto_err=%b cmd_ready=%b err_cnt=%0d required 1/1/0",
                     proto_err, cmd_ready, err_cnt);
        end
    endtask

    task automatic test_early_last();
        // Read ended by app_last_rd on beat 1 of 4
        do_reset();
        issue_cmd(1'b1, 32'h700, 8'd4, 32'h40);
        app_req_ack = 1'b1;
        tick();
        clear_inputs();
        app_rd_valid = 1'b1;
        app_rd_data  = 32'h40;
        tick();
        clear_inputs();
        app_rd_valid = 1'b1;
        app_rd_data  = 32'h41;
        app_last_rd  = 1'b1;
        tick();
        clear_inputs();
        check_finish("early_last_rd", 1'b1);
        // Write ended by app_last_wr on beat 1 of 4
        do_reset();
        issue_cmd(1'b0, 32'h800, 8'd4, 32'h50);
        app_req_ack     = 1'b1;
        app_wr_next_req = 1'b1;
        tick();
        clear_inputs();
        app_wr_next_req = 1'b1;
        app_last_wr     = 1'b1;
        tick();
        clear_inputs();
        check_finish("early_last_wr", 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_write_basic();
        test_read_corrupt();
        test_ack_delay();
        test_zero_len();
        test_write_wrap();
        test_random();
        test_reset_mid_burst();
        test_stray_idle();
        test_early_last();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdr_app_master.md
SDR_APP_MASTER -- requirements
Module: sdr_app_master
Interface
REQ-001 SHALL have parameter AW, default `APP_AW, application address width.
REQ-002 SHALL have parameter DW, default `APP_DW, application data width; byte-enable width BW = DW/8.
REQ-003 SHALL have parameter RW, default `APP_RW, request length width.
REQ-004 sdram_clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  one clock; reset is synchronous and active-high.
REQ-006 cmd_valid  in  1  user command offered.
REQ-007 cmd_ready  out  1  block idle, command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_wr_n  in  1  0 write, 1 read.
REQ-009 cmd_addr  in  AW  start address.
REQ-010 cmd_len  in  RW  burst length in DW-bit beats.
REQ-011 cmd_seed  in  DW  data pattern seed.
REQ-012 app_req  out  1  request to controller.
REQ-013 app_req_addr  out  AW  registered cmd_addr.
REQ-014 app_req_len  out  RW  registered cmd_len.
REQ-015 app_req_wr_n  out  1  registered cmd_wr_n.
REQ-016 app_req_wrap  out  1  constant 0.
REQ-017 app_wr_data  out  DW  current write beat = seed + beat index.
REQ-018 app_wr_en_n  out  BW  constant all-zero (all bytes written).
REQ-019 app_req_ack  in  1  controller accepted request.
REQ-020 app_wr_next_req  in  1  controller consumes current write beat this cycle.
REQ-021 app_rd_data  in  DW  read beat.
REQ-022 app_rd_valid  in  1  app_rd_data valid.
REQ-023 app_last_rd / app_last_wr  in  1 each  final read / write beat marker.
REQ-024 done  out  1  one-cycle pulse at burst completion.
REQ-025 err_cnt  out  16  saturating read-mismatch count; proto_err  out  1  sticky protocol violation.
Function
REQ-026 FSM states IDLE, REQ, WDATA, RDATA, DONE; cmd_ready=1 only in IDLE.
REQ-027 IDLE: accepted command with cmd_len!=0 registers addr/len/wr_n/seed, clears beat counter, enters REQ next cycle; cmd_len==0 goes directly to DONE, no app_req.
REQ-028 REQ: app_req=1 with address/len/wr_n stable until cycle app_req_ack=1; then WDATA if write, RDATA if read.
REQ-029 WDATA: app_wr_data valid from first REQ cycle; beat counter increments on each app_wr_next_req (may coincide with app_req_ack); exit to DONE after beat len-1 consumed; app_last_wr on any earlier beat sets proto_err and exits.
REQ-030 RDATA: each app_rd_valid compares app_rd_data to seed+beat (mod 2^DW), increments beat; exit to DONE on app_last_rd; app_last_rd before beat len-1 or app_rd_valid after beat len-1 sets proto_err.
REQ-031 app_rd_valid or app_wr_next_req in IDLE/DONE sets proto_err; beat ignored.
REQ-032 DONE: done=1 for exactly one cycle, then IDLE; min command-to-command spacing 3 cycles.
REQ-033 err_cnt increments by 1 per mismatched beat, saturates at 16'hFFFF; held across commands.
Reset
REQ-034 On reset: state IDLE, app_req=0, done=0, cmd_ready=1 next cycle, err_cnt=0, proto_err=0, counters and registered fields 0; reset mid-burst drops app_req same edge.
Configuration
REQ-035 With SDR_APP_MASTER_CHECK_EN defined, REQ-030/033 compare logic is built; without it err_cnt is tied 0, read beats only counted, proto_err still active.
Structure
REQ-036 FSM state enum and width constants SHALL live in shared package sdr_app_pkg; data pattern/compare logic SHALL be sub-module sdr_app_pattern.
Verification
REQ-037 Write addr=0x100 len=4 seed=0xA000_0000, next_req on 4 cycles -> data 0xA0000000..0xA0000003, one done pulse.
REQ-038 Read len=8 seed=5, returned 5..12, beat 3 corrupted -> err_cnt=1, done after app_last_rd.
REQ-039 app_req_ack delayed 10 cycles -> app_req and address stable all 10 cycles.
REQ-040 cmd_len=0 -> no app_req, done one cycle later; seed=0xFFFF_FFFF write len=2 -> data 0xFFFFFFFF, 0x00000000.
REQ-041 reset asserted in WDATA after beat 1 -> app_req=0, state IDLE, err_cnt=0; stray app_rd_valid in IDLE -> proto_err=1.
